// File: rtl/bcast_fifo_pkg.sv
// rtl/bcast_fifo_pkg.sv - shared constants and helpers for the broadcast FIFO controller
// Contents: NUM_RD (number of readers) and ptr_w(), the pointer width for a given depth.
package bcast_fifo_pkg;

    localparam int NUM_RD = 2;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bcast_rd_port.sv
// rtl/bcast_rd_port.sv - per-reader pointer, occupancy, pop/flush handling
// Ports: clk, rst; pop, flush requests; wr_en and wr_ptr_nxt from the writer;
//        rd_addr, count, empty (registered); count_nxt, blocks_push, udf_set (combinational).
module bcast_rd_port
    import bcast_fifo_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int A_WIDTH = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pop,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [A_WIDTH:0]   wr_ptr_nxt,
    output logic [A_WIDTH-1:0] rd_addr,
    output logic [A_WIDTH:0]   count,
    output logic [A_WIDTH:0]   count_nxt,
    output logic               empty,
    output logic               blocks_push,
    output logic               udf_set
);

    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic          has_data;
    logic          pop_ok;

    assign has_data = (count != '0);

    // A reader sitting at DEPTH holds off the writer unless it frees a slot this cycle.
    assign blocks_push = (count == PW'(DEPTH)) && !(pop && has_data);

    // An empty reader may still pop if the writer supplies the word this cycle.
    assign pop_ok  = pop && !flush && (has_data || wr_en);
    assign udf_set = pop && !flush && !pop_ok;

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            // Jump to the post-edge write pointer so a same-cycle push is discarded too.
            rd_ptr_nxt = wr_ptr_nxt;
        end else if (pop_ok) begin
            rd_ptr_nxt = rd_ptr + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    assign count_nxt = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            empty  <= (count_nxt == '0);
        end
    end

    assign rd_addr = rd_ptr[A_WIDTH-1:0];

endmodule

// File: rtl/bcast_fifo_ctrl.sv
// rtl/bcast_fifo_ctrl.sv - one-writer two-reader broadcast FIFO pointer/flow controller
// Ports: clk, rst; push, pop_a/pop_b, flush_a/flush_b requests; wr_en (combinational),
//        wr_addr, rd_addr_a/b, count_a/b, empty_a/b, full (registered); ovf, udf (sticky).
module bcast_fifo_ctrl
    import bcast_fifo_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int A_WIDTH = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop_a,
    input  logic               pop_b,
    input  logic               flush_a,
    input  logic               flush_b,
    output logic               wr_en,
    output logic [A_WIDTH-1:0] wr_addr,
    output logic [A_WIDTH-1:0] rd_addr_a,
    output logic [A_WIDTH-1:0] rd_addr_b,
    output logic [A_WIDTH:0]   count_a,
    output logic [A_WIDTH:0]   count_b,
    output logic               empty_a,
    output logic               empty_b,
    output logic               full,
    output logic               ovf,
    output logic               udf
);

    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     wr_ptr_nxt;
    logic [PW-1:0]     count_a_nxt;
    logic [PW-1:0]     count_b_nxt;
    logic [NUM_RD-1:0] blocks;
    logic [NUM_RD-1:0] udf_sets;

    assign wr_en      = push && !rst && (blocks == '0);
    assign wr_ptr_nxt = wr_ptr + {{(PW-1){1'b0}}, wr_en};

    bcast_rd_port #(.DEPTH(DEPTH), .A_WIDTH(A_WIDTH)) u_port_a (
        .clk         (clk),
        .rst         (rst),
        .pop         (pop_a),
        .flush       (flush_a),
        .wr_en       (wr_en),
        .wr_ptr_nxt  (wr_ptr_nxt),
        .rd_addr     (rd_addr_a),
        .count       (count_a),
        .count_nxt   (count_a_nxt),
        .empty       (empty_a),
        .blocks_push (blocks[0]),
        .udf_set     (udf_sets[0])
    );

    bcast_rd_port #(.DEPTH(DEPTH), .A_WIDTH(A_WIDTH)) u_port_b (
        .clk         (clk),
        .rst         (rst),
        .pop         (pop_b),
        .flush       (flush_b),
        .wr_en       (wr_en),
        .wr_ptr_nxt  (wr_ptr_nxt),
        .rd_addr     (rd_addr_b),
        .count       (count_b),
        .count_nxt   (count_b_nxt),
        .empty       (empty_b),
        .blocks_push (blocks[1]),
        .udf_set     (udf_sets[1])
    );

    // Counts never exceed DEPTH, so the larger one equals DEPTH iff either does.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            full   <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            full   <= (count_a_nxt == PW'(DEPTH)) || (count_b_nxt == PW'(DEPTH));
            if (push && !wr_en) begin
                ovf <= 1'b1;
            end
            if (udf_sets != '0) begin
                udf <= 1'b1;
            end
        end
    end

    assign wr_addr = wr_ptr[A_WIDTH-1:0];

endmodule

// File: tb/tb_bcast_fifo_ctrl.sv
// tb/tb_bcast_fifo_ctrl.sv - self-checking bench for bcast_fifo_ctrl (DEPTH=4)
module tb_bcast_fifo_ctrl;

    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0, pop_a = 1'b0, pop_b = 1'b0, flush_a = 1'b0, flush_b = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [AW:0]   count_a, count_b;
    logic          empty_a, empty_b, full, ovf, udf;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: running totals of words written and consumed per reader.
    int m_w, m_a, m_b;
    bit m_ovf, m_udf;

    always #5 clk = ~clk;

    bcast_fifo_ctrl #(.DEPTH(D)) dut (
        .clk(clk), .rst(rst), .push(push), .pop_a(pop_a), .pop_b(pop_b),
        .flush_a(flush_a), .flush_b(flush_b), .wr_en(wr_en), .wr_addr(wr_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .count_a(count_a), .count_b(count_b),
        .empty_a(empty_a), .empty_b(empty_b), .full(full), .ovf(ovf), .udf(udf)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; push = 1'b0; pop_a = 1'b0; pop_b = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
        @(posedge clk); #1;
        m_w = 0; m_a = 0; m_b = 0; m_ovf = 0; m_udf = 0;
    endtask

    // Applies one cycle of inputs, returns model and observed wr_en, advances the model.
    task automatic drive(input bit p, input bit pa, input bit pb, input bit fa, input bit fb,
                         output bit exp_we, output logic obs_we);
        int ca, cb, nw;
        bit ok_a, ok_b;
        @(negedge clk);
        rst = 1'b0; push = p; pop_a = pa; pop_b = pb; flush_a = fa; flush_b = fb;
        #1;
        obs_we = wr_en;
        ca = m_w - m_a;
        cb = m_w - m_b;
        exp_we = p && (ca < D || (pa && ca != 0)) && (cb < D || (pb && cb != 0));
        nw   = m_w + (exp_we ? 1 : 0);
        ok_a = pa && !fa && (ca != 0 || exp_we);
        ok_b = pb && !fb && (cb != 0 || exp_we);
        if (p && !exp_we) m_ovf = 1;
        if ((pa && !fa && !ok_a) || (pb && !fb && !ok_b)) m_udf = 1;
        m_a = fa ? nw : m_a + (ok_a ? 1 : 0);
        m_b = fb ? nw : m_b + (ok_b ? 1 : 0);
        m_w = nw;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; push = 1'b1; pop_a = 1'b1; pop_b = 1'b1;
        #1;
        n_total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b exp 0", wr_en); else n_pass++;
        @(posedge clk); #1;
        m_w = 0; m_a = 0; m_b = 0; m_ovf = 0; m_udf = 0;
        n_total++; if (count_a !== 3'd0 || count_b !== 3'd0) $display("FAIL reset_counts got %0d/%0d exp 0/0", count_a, count_b); else n_pass++;
        n_total++; if (empty_a !== 1'b1 || empty_b !== 1'b1) $display("FAIL reset_empty got %b%b exp 11", empty_a, empty_b); else n_pass++;
        n_total++; if (full !== 1'b0 || ovf !== 1'b0 || udf !== 1'b0) $display("FAIL reset_flags got full=%b ovf=%b udf=%b exp 000", full, ovf, udf); else n_pass++;
        n_total++; if (wr_addr !== 2'd0 || rd_addr_a !== 2'd0 || rd_addr_b !== 2'd0) $display("FAIL reset_addrs got %0d %0d %0d exp 0 0 0", wr_addr, rd_addr_a, rd_addr_b); else n_pass++;
    endtask

    task automatic test_fill_overflow();
        bit e; logic o;
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, e, o);
        n_total++; if (count_a !== 3'd4 || count_b !== 3'd4) $display("FAIL fill_counts got %0d/%0d exp 4/4", count_a, count_b); else n_pass++;
        n_total++; if (full !== 1'b1 || ovf !== 1'b0 || wr_addr !== 2'd0) $display("FAIL fill_state got full=%b ovf=%b wr_addr=%0d exp 1 0 0", full, ovf, wr_addr); else n_pass++;
        drive(1, 0, 0, 0, 0, e, o);
        n_total++; if (o !== 1'b0) $display("FAIL ovf_wr_en got %b exp 0", o); else n_pass++;
        n_total++; if (ovf !== 1'b1 || count_a !== 3'd4 || count_b !== 3'd4) $display("FAIL ovf_state got ovf=%b counts=%0d/%0d exp 1 4/4", ovf, count_a, count_b); else n_pass++;
    endtask

    task automatic test_pop_a_only();
        bit e; logic o; bit saw_full;
        do_reset();
        saw_full = 0;
        for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 0, 0, e, o); if (full) saw_full = 1; end
        for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0, 0, e, o); if (full) saw_full = 1; end
        n_total++; if (count_a !== 3'd0 || empty_a !== 1'b1 || rd_addr_a !== 2'd3) $display("FAIL popa_a got cnt=%0d empty=%b addr=%0d exp 0 1 3", count_a, empty_a, rd_addr_a); else n_pass++;
        n_total++; if (count_b !== 3'd3 || empty_b !== 1'b0) $display("FAIL popa_b got cnt=%0d empty=%b exp 3 0", count_b, empty_b); else n_pass++;
        n_total++; if (saw_full !== 1'b0) $display("FAIL popa_full got %b exp 0", saw_full); else n_pass++;
    endtask

    task automatic test_full_pop_both();
        bit e; logic o;
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, e, o);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, e, o);
        n_total++; if (full !== 1'b1 || wr_addr !== 2'd3 || rd_addr_a !== 2'd3) $display("FAIL prewrap got full=%b wr=%0d rda=%0d exp 1 3 3", full, wr_addr, rd_addr_a); else n_pass++;
        drive(1, 1, 1, 0, 0, e, o);
        n_total++; if (o !== 1'b1) $display("FAIL fullpop_wr_en got %b exp 1", o); else n_pass++;
        n_total++; if (count_a !== 3'd4 || count_b !== 3'd4 || full !== 1'b1) $display("FAIL fullpop_counts got %0d/%0d full=%b exp 4/4 1", count_a, count_b, full); else n_pass++;
        n_total++; if (wr_addr !== 2'd0 || rd_addr_a !== 2'd0 || rd_addr_b !== 2'd0) $display("FAIL wrap_addrs got %0d %0d %0d exp 0 0 0", wr_addr, rd_addr_a, rd_addr_b); else n_pass++;
        // B still at DEPTH and not popping: push must be dropped.
        drive(1, 1, 0, 0, 0, e, o);
        n_total++; if (o !== 1'b0 || ovf !== 1'b1) $display("FAIL single_pop got wr_en=%b ovf=%b exp 0 1", o, ovf); else n_pass++;
        n_total++; if (count_a !== 3'd3 || count_b !== 3'd4 || full !== 1'b1) $display("FAIL single_pop_counts got %0d/%0d full=%b exp 3/4 1", count_a, count_b, full); else n_pass++;
    endtask

    task automatic test_fallthrough();
        bit e; logic o;
        do_reset();
        drive(1, 1, 0, 0, 0, e, o);
        n_total++; if (o !== 1'b1) $display("FAIL ft_wr_en got %b exp 1", o); else n_pass++;
        n_total++; if (count_a !== 3'd0 || count_b !== 3'd1 || udf !== 1'b0) $display("FAIL ft_state got %0d/%0d udf=%b exp 0/1 0", count_a, count_b, udf); else n_pass++;
        drive(0, 0, 1, 0, 0, e, o);
        n_total++; if (count_b !== 3'd0 || rd_addr_b !== 2'd1 || udf !== 1'b0) $display("FAIL drain_b got cnt=%0d addr=%0d udf=%b exp 0 1 0", count_b, rd_addr_b, udf); else n_pass++;
        drive(0, 0, 1, 0, 0, e, o);
        n_total++; if (udf !== 1'b1 || rd_addr_b !== 2'd1) $display("FAIL udf got udf=%b addr=%0d exp 1 1", udf, rd_addr_b); else n_pass++;
    endtask

    task automatic test_flush();
        bit e; logic o;
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, e, o);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, e, o);
        drive(0, 0, 0, 0, 1, e, o);
        n_total++; if (count_b !== 3'd0 || empty_b !== 1'b1 || full !== 1'b0) $display("FAIL flush got cnt=%0d empty=%b full=%b exp 0 1 0", count_b, empty_b, full); else n_pass++;
        n_total++; if (count_a !== 3'd1 || rd_addr_b !== 2'd0) $display("FAIL flush_other got cnta=%0d rdb=%0d exp 1 0", count_a, rd_addr_b); else n_pass++;
        for (int i = 0; i < 10; i++) drive(1, 1, 1, 0, 0, e, o);
        n_total++; if (ovf !== 1'b0 || udf !== 1'b0) $display("FAIL stream_flags got ovf=%b udf=%b exp 0 0", ovf, udf); else n_pass++;
        n_total++; if (count_a !== 3'd1 || count_b !== 3'd0 || wr_addr !== 2'd2 || rd_addr_a !== 2'd1) $display("FAIL stream_state got %0d/%0d wr=%0d rda=%0d exp 1/0 2 1", count_a, count_b, wr_addr, rd_addr_a); else n_pass++;
    endtask

    task automatic test_random();
        bit e; logic o;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, e, o);
                n_total++; if (o !== e) $display("FAIL rnd_wr_en cyc %0d got %b exp %b", i, o, e); else n_pass++;
            end
            n_total++; if (count_a !== 3'(m_w - m_a) || count_b !== 3'(m_w - m_b)) $display("FAIL rnd_counts cyc %0d got %0d/%0d exp %0d/%0d", i, count_a, count_b, m_w - m_a, m_w - m_b); else n_pass++;
            n_total++; if (wr_addr !== 2'(m_w % D) || rd_addr_a !== 2'(m_a % D) || rd_addr_b !== 2'(m_b % D)) $display("FAIL rnd_addrs cyc %0d got %0d %0d %0d exp %0d %0d %0d", i, wr_addr, rd_addr_a, rd_addr_b, m_w % D, m_a % D, m_b % D); else n_pass++;
            n_total++; if (empty_a !== (m_w == m_a) || empty_b !== (m_w == m_b)) $display("FAIL rnd_empty cyc %0d got %b%b", i, empty_a, empty_b); else n_pass++;
            n_total++; if (full !== ((m_w - m_a) == D || (m_w - m_b) == D)) $display("FAIL rnd_full cyc %0d got %b", i, full); else n_pass++;
            n_total++; if (ovf !== m_ovf || udf !== m_udf) $display("FAIL rnd_sticky cyc %0d got ovf=%b udf=%b exp %b %b", i, ovf, udf, m_ovf, m_udf); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_pop_a_only();
        test_full_pop_both();
        test_fallthrough();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
